// File: rtl/sqrt_formula_pkg.sv
// Constants shared by the square-root formula pool and its result buffer.
package sqrt_formula_pkg;

  localparam int FORMULA_DATA_W   = 32;
  localparam int RESULT_BUF_DEPTH = 8;

endpackage

// File: rtl/sqrt_result_fifo.sv
// Storage and read/write pointers for the result buffer. The caller qualifies
// wr_en/rd_en; this block only tracks occupancy and wraps pointers.
module sqrt_result_fifo
  import sqrt_formula_pkg::*;
#(
  parameter int DEPTH = RESULT_BUF_DEPTH,
  parameter int W     = FORMULA_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // DEPTH is a power of two, so pointer wrap is the natural carry-out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/sqrt_result_buffer.sv
// Result buffer behind the sqrt formula pool: FIFO plus credit tracking.
// Define SQRT_RESULT_BUFFER_OVERFLOW_CHECK_EN to enable the sticky overflow flag.
module sqrt_result_buffer
  import sqrt_formula_pkg::*;
#(
  parameter int DEPTH = RESULT_BUF_DEPTH,
  parameter int W     = FORMULA_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arg_vld,
  output logic                       arg_rdy,
  input  logic                       res_vld,
  input  logic [W-1:0]               res,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int LVL_W = $clog2(DEPTH+1);

  logic [LVL_W-1:0] fifo_level;
  logic [LVL_W-1:0] inflight_q, inflight_d;
  logic             full;
  logic             pop;
  logic             push;

  assign full    = (fifo_level == LVL_W'(DEPTH));
  assign out_vld = (fifo_level != '0);
  assign pop     = out_vld && out_rdy;
  // A full buffer still takes a beat when a slot frees in the same cycle.
  assign push    = res_vld && (!full || pop);

  sqrt_result_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (res),
    .rd_en   (pop),
    .rd_data (out_data),
    .level   (fifo_level)
  );

  always_comb begin
    inflight_d = inflight_q;
    case ({arg_vld, res_vld})
      2'b10:   if (inflight_q != LVL_W'(DEPTH)) inflight_d = inflight_q + LVL_W'(1);
      2'b01:   if (inflight_q != '0)            inflight_d = inflight_q - LVL_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  // Credit uses registered state only, one bit wider so the sum cannot wrap.
  assign arg_rdy = ({1'b0, fifo_level} + {1'b0, inflight_q}) < (LVL_W+1)'(DEPTH);
  assign level   = fifo_level;

`ifdef SQRT_RESULT_BUFFER_OVERFLOW_CHECK_EN
  logic drop;
  logic overflow_q, overflow_d;

  assign drop = res_vld && full && !pop;

  always_comb begin
    overflow_d = overflow_q;
    if (drop || (arg_vld && !arg_rdy)) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// Scoreboard bench for sqrt_result_buffer: ordering, credit, backpressure,
// full write+pop, overflow and a random stream that wraps the pointers.
module tb_sqrt_result_buffer;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             arg_vld;
  logic             arg_rdy;
  logic             res_vld;
  logic [W-1:0]     res;
  logic             out_vld;
  logic             out_rdy;
  logic [W-1:0]     out_data;
  logic [LVL_W-1:0] level;
  logic             overflow;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;

  always #5 clk = ~clk;

  sqrt_result_buffer #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arg_vld  (arg_vld),
    .arg_rdy  (arg_rdy),
    .res_vld  (res_vld),
    .res      (res),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .level    (level),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Evaluate the coming edge against the scoreboard, then advance one cycle.
  task automatic tick();
    logic pop_m;
    pop_m = (exp_q.size() > 0) && out_rdy;
    chk("out_vld", out_vld, exp_q.size() > 0);
    if (pop_m) chk("out_data", out_data, exp_q.pop_front());
    if (res_vld && (exp_q.size() < DEPTH || pop_m)) exp_q.push_back(res);
    if (rst) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [W-1:0] base);
    out_rdy = 1'b0;
    res_vld = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      res = base + W'(i);
      tick();
    end
    res_vld = 1'b0;
  endtask

  initial begin
`ifdef SQRT_RESULT_BUFFER_OVERFLOW_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst = 1'b1; arg_vld = 1'b0; res_vld = 1'b0; res = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_level", level, 0);
    chk("rst_arg_rdy", arg_rdy, 1);
    chk("rst_overflow", overflow, 0);

    // ordering
    out_rdy = 1'b1; res_vld = 1'b1; res = 32'h10;
    tick();
    chk("order_vld_next", out_vld, 1);
    res = 32'h20; tick();
    res = 32'h30; tick();
    res_vld = 1'b0;
    repeat (3) tick();
    chk("order_level", level, 0);

    // credit
    out_rdy = 1'b0; arg_vld = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("credit_rdy", arg_rdy, (i < DEPTH - 1));
    end
    arg_vld = 1'b0;
    res_vld = 1'b1; res = 32'h55; out_rdy = 1'b1;
    tick();
    res_vld = 1'b0;
    chk("credit_hold", arg_rdy, 0);
    tick();
    chk("credit_back", arg_rdy, 1);
    chk("credit_ovf", overflow, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_arg_rdy", arg_rdy, 1);

    // backpressure
    fill(32'hA0);
    chk("bp_level", level, DEPTH);
    chk("bp_head", out_data, 32'hA0);
    tick(); tick();
    chk("bp_hold", out_data, 32'hA0);
    out_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("bp_level_dec", level, DEPTH - 1 - i);
    end

    // full with simultaneous write and pop
    fill(32'hB0);
    res_vld = 1'b1; res = 32'hCC; out_rdy = 1'b1;
    tick();
    res_vld = 1'b0;
    chk("wp_level", level, DEPTH);
    repeat (DEPTH) tick();
    chk("wp_drained", level, 0);

    // overflow by dropped beat
    fill(32'hD0);
    res_vld = 1'b1; res = 32'hEE;
    tick();
    res_vld = 1'b0;
    chk("ovf_level", level, DEPTH);
    chk("ovf_set", overflow, exp_ovf);
    tick(); tick();
    chk("ovf_sticky", overflow, exp_ovf);
    out_rdy = 1'b1;
    repeat (DEPTH + 1) tick();
    chk("ovf_after_drain", overflow, exp_ovf);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_rst", overflow, 0);

    // overflow by arg_vld without credit
    arg_vld = 1'b1;
    repeat (DEPTH + 1) tick();
    arg_vld = 1'b0;
    chk("ovf_arg", overflow, exp_ovf);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_arg_rst", overflow, 0);

    // random stream, wraps pointers several times
    for (int i = 0; i < 80; i++) begin
      res_vld = 1'($urandom_range(0, 1));
      res     = $urandom;
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
      chk("rnd_level", level, exp_q.size());
    end
    res_vld = 1'b0; out_rdy = 1'b1;
    repeat (DEPTH + 2) tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_result_buffer.md
SQRT_RESULT_BUFFER -- requirements
Module: sqrt_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter W, default 32: result data width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port arg_vld, input, 1: upstream launched one argument triple into the formula pool this cycle.
REQ-006 SHALL have port arg_rdy, output, 1: credit; upstream may assert arg_vld only while high.
REQ-007 SHALL have port res_vld, input, 1: formula pool result valid (one per cycle max).
REQ-008 SHALL have port res, input, W: formula pool result data.
REQ-009 SHALL have port out_vld, output, 1: buffered result available.
REQ-010 SHALL have port out_rdy, input, 1: downstream accepts out_data when out_vld && out_rdy.
REQ-011 SHALL have port out_data, output, W: oldest buffered result.
REQ-012 SHALL have port level, output, $clog2(DEPTH+1): current FIFO occupancy.
REQ-013 SHALL have port overflow, output, 1: sticky protocol-error flag.

Function
REQ-014 SHALL store each res_vld beat in arrival order; out_data SHALL present entries strictly FIFO.
REQ-015 SHALL register writes: a result written at edge k SHALL produce out_vld=1 from cycle k+1; no combinational res->out_data path.
REQ-016 SHALL pop one entry per cycle when out_vld && out_rdy; out_rdy while empty SHALL have no effect.
REQ-017 SHALL track in-flight count: +1 on arg_vld, -1 on res_vld, unchanged when both, saturate at 0 and at DEPTH.
REQ-018 SHALL drive arg_rdy = (level + inflight) < DEPTH, from registered state only.
REQ-019 SHALL, when full, accept a res_vld beat coinciding with a pop (level unchanged); with no pop the beat SHALL be dropped.
REQ-020 SHALL, on a dropped beat or on arg_vld while arg_rdy=0, set overflow (see REQ-026).
REQ-021 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entry.
REQ-022 SHALL keep out_data stable while out_vld && !out_rdy.

Reset
REQ-023 SHALL on rst: level=0, inflight=0, pointers=0, out_vld=0, arg_rdy=1, overflow=0; storage contents need not reset.
REQ-024 SHALL on rst mid-operation discard all buffered and in-flight bookkeeping; results arriving after reset count as new beats.

Configuration
REQ-025 SHALL support macro SQRT_RESULT_BUFFER_OVERFLOW_CHECK_EN.
REQ-026 SHALL, with the macro defined, implement overflow as sticky, cleared only by rst; without it, overflow SHALL be tied 0 and dropped beats remain silent.

Structure
REQ-027 SHALL take W default and DEPTH default from shared package sqrt_formula_pkg (constants FORMULA_DATA_W=32, RESULT_BUF_DEPTH=8).
REQ-028 SHALL place storage and pointers in one sub-module sqrt_result_fifo; credit and overflow logic in the top.

Verification
REQ-029 SHALL test reset: assert rst 2 cycles -> out_vld=0, level=0, arg_rdy=1, overflow=0.
REQ-030 SHALL test ordering: results 0x10,0x20,0x30 on consecutive cycles, out_rdy=1 -> out_data 0x10,0x20,0x30 one cycle later each.
REQ-031 SHALL test credit: DEPTH=8, 8 arg_vld with no results -> arg_rdy=0 after 8th; one res_vld + pop -> arg_rdy=1 next cycle.
REQ-032 SHALL test backpressure: fill 8 with out_rdy=0 -> level=8, out_data holds 1st value; release -> drains in order with level decrementing by 1.
REQ-033 SHALL test full plus simultaneous write and pop: level stays 8, new value emerges 8th.
REQ-034 SHALL test overflow with macro: 9th res_vld while full, no pop -> overflow=1 until rst and 9th value never appears; without macro -> overflow=0.
